// File: rtl/cpld_iox_pkg.sv
// cpld_iox_pkg: frame layout shared by the CPLD I/O expander and its bench
package cpld_iox_pkg;
   localparam int FRAME_W   = 16;
   localparam int LED_LSB   = 0;
   localparam int DISP_LSB  = 8;
   localparam int DIPSW_LSB = 1;
   localparam int NAVSW_LSB = 9;
   localparam int DSEL_BIT  = 14;
   typedef logic [FRAME_W-1:0] frame_t;
   function automatic frame_t tx_word(input logic dsel, input logic [4:0] nav, input logic [7:0] dip);
      frame_t w = '0;
      w[DSEL_BIT]        = dsel;
      w[NAVSW_LSB +: 5]  = nav;
      w[DIPSW_LSB +: 8]  = dip;
      return w;
   endfunction
endpackage

// File: rtl/cpld_iox_sync_edge.sv
// cpld_iox_sync_edge: N-stage synchronizer, W bits wide, with registered rise/fall pulses
module cpld_iox_sync_edge #(
   parameter int N = 2,
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic [W-1:0] d,
   output logic [W-1:0] q,
   output logic [W-1:0] rise,
   output logic [W-1:0] fall
);
   logic [N-1:0][W-1:0] s;
   always_ff @(posedge clk)
      if (!rstn) begin
         s    <= '0;
         rise <= '0;
         fall <= '0;
      end else begin
         s    <= {s[N-2:0], d};
         rise <= s[N-2] & ~s[N-1];
         fall <= ~s[N-2] & s[N-1];
      end
   assign q = s[N-1];
endmodule

// File: rtl/cpld_io_expander.sv
// cpld_io_expander: board-side end of the serial I/O link (LED / two digits in, switches out).
// Define CPLD_IOX_DEBOUNCE_EN to synchronize and debounce dipsw_in/navsw_in.
module cpld_io_expander import cpld_iox_pkg::*; #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       cpld_rstn,
   input  logic       cpld_clk,
   input  logic       cpld_load,
   input  logic       cpld_mosi,
   output logic       cpld_miso,
   input  logic [7:0] dipsw_in,
   input  logic [4:0] navsw_in,
   output logic [7:0] led_out,
   output logic [7:0] dig0_out,
   output logic [7:0] dig1_out,
   output logic       frame_done,
   output logic       frame_err
);
   logic       clk_rise, clk_fall, unused_clk_s;
   logic       link_rstn_s, load_s, mosi_s;
   logic [2:0] unused_rise, unused_fall;
   logic       srst, accept, dig_sel;
   logic [3:0] bit_cnt;
   logic [7:0] dip_v;
   logic [4:0] nav_v;
   frame_t     rx_shr, tx_shr, rx_next;

   cpld_iox_sync_edge #(.N(SYNC_STAGES), .W(1)) u_clk_sync (
      .clk(clk), .rstn(rstn), .d(cpld_clk), .q(unused_clk_s), .rise(clk_rise), .fall(clk_fall)
   );
   cpld_iox_sync_edge #(.N(SYNC_STAGES), .W(3)) u_lvl_sync (
      .clk(clk), .rstn(rstn), .d({cpld_rstn, cpld_load, cpld_mosi}),
      .q({link_rstn_s, load_s, mosi_s}), .rise(unused_rise), .fall(unused_fall)
   );

   assign srst    = !rstn || !link_rstn_s;
   assign rx_next = {mosi_s, rx_shr[FRAME_W-1:1]};
   assign accept  = clk_rise & load_s;

`ifdef CPLD_IOX_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   logic [12:0] sw_raw, sw_db;
   assign sw_raw = {navsw_in, dipsw_in};
   for (genvar i = 0; i < 13; i++) begin : g_db
      logic [1:0]    sy;
      logic [CW-1:0] cnt;
      logic          db;
      // a new level must persist DEBOUNCE_CYCLES consecutive cycles before it is taken
      always_ff @(posedge clk)
         if (srst) begin
            sy  <= '0;
            cnt <= '0;
            db  <= 1'b0;
         end else begin
            sy <= {sy[0], sw_raw[i]};
            if (sy[1] == db) cnt <= '0;
            else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
               db  <= sy[1];
               cnt <= '0;
            end else cnt <= cnt + CW'(1);
         end
      assign sw_db[i] = db;
   end
   assign {nav_v, dip_v} = sw_db;
`else
   assign dip_v = dipsw_in;
   assign nav_v = navsw_in;
`endif

   always_ff @(posedge clk)
      if (srst) begin
         rx_shr     <= '0;
         tx_shr     <= '0;
         bit_cnt    <= '0;
         dig_sel    <= 1'b0;
         led_out    <= '0;
         dig0_out   <= '0;
         dig1_out   <= '0;
         cpld_miso  <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         frame_done <= accept;
         cpld_miso  <= tx_shr[0];
         if (clk_rise) begin
            rx_shr  <= rx_next;
            bit_cnt <= accept ? 4'd0 : bit_cnt + 4'd1;
         end
         if (accept) begin
            led_out <= rx_next[LED_LSB +: 8];
            if (dig_sel) dig1_out <= rx_next[DISP_LSB +: 8];
            else dig0_out <= rx_next[DISP_LSB +: 8];
            dig_sel <= ~dig_sel;
            tx_shr  <= tx_word(~dig_sel, nav_v, dip_v);
            if (bit_cnt != 4'd15) frame_err <= 1'b1;
         end else if (clk_fall) tx_shr <= {1'b0, tx_shr[FRAME_W-1:1]};
      end
endmodule
